// File: rtl/card_shuffler.sv
// Sequential Fisher-Yates deck shuffler: one swap per clock, start/busy/done handshake.
// Optional pair-count self-check is enabled by defining SHUFFLE_CHECK_EN.
module card_shuffler #(
    parameter int                NUM_PAIRS = 8,
    parameter int                SYM_W     = 3,
    parameter int                CARD_W    = 5,
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [LFSR_W-1:0]                     seed,
    output logic [2*NUM_PAIRS-1:0][CARD_W-1:0]    arr_cards,
    output logic                                  busy,
    output logic                                  done
`ifdef SHUFFLE_CHECK_EN
    ,
    output logic                                  err
`endif
);

    localparam int N      = 2 * NUM_PAIRS;
    localparam int IDX_W  = $clog2(N);
    localparam int STAT_W = CARD_W - SYM_W;
    localparam int PW     = LFSR_W + IDX_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SWAP  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef SHUFFLE_CHECK_EN
    localparam logic [2:0] S_CHECK = 3'd4;
`endif

    logic [2:0]                   state_q, state_d;
    logic [LFSR_W-1:0]            lfsr_q, lfsr_d;
    logic [SYM_W-1:0]             pool_q [N];
    logic [SYM_W-1:0]             pool_d [N];
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [N-1:0][CARD_W-1:0]     cards_q, cards_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
`ifdef SHUFFLE_CHECK_EN
    logic                         err_q, err_d;
    logic [SYM_W-1:0]             chk_q, chk_d;
    logic [IDX_W:0]               sym_cnt;
`endif

    logic                         fb;
    logic [LFSR_W-1:0]            lfsr_nx;
    logic [PW-1:0]                mul_a, mul_b, prod;
    logic [IDX_W-1:0]             j;

    // Multiply-high maps the fresh LFSR word onto 0..i without a modulo.
    always_comb begin
        fb      = ^(lfsr_q & LFSR_TAPS);
        lfsr_nx = {lfsr_q[LFSR_W-2:0], fb};
        mul_a   = PW'(lfsr_nx);
        mul_b   = PW'(idx_q) + PW'(1);
        prod    = mul_a * mul_b;
        j       = IDX_W'(prod >> LFSR_W);
    end

`ifdef SHUFFLE_CHECK_EN
    always_comb begin
        sym_cnt = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cards_q[k][CARD_W-1 -: SYM_W] == chk_q) begin
                sym_cnt = sym_cnt + (IDX_W+1)'(1);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        pool_d  = pool_q;
        idx_d   = idx_q;
        cards_d = cards_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef SHUFFLE_CHECK_EN
        err_d   = err_q;
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Seed is captured here so later seed changes cannot affect this run.
                    lfsr_d  = (seed == '0) ? '1 : seed;
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
`ifdef SHUFFLE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                for (int unsigned k = 0; k < N; k++) begin
                    pool_d[k] = SYM_W'(k / 2);
                end
                idx_d   = IDX_W'(N - 1);
                state_d = S_SWAP;
            end
            S_SWAP: begin
                lfsr_d        = lfsr_nx;
                pool_d[idx_q] = pool_q[j];
                pool_d[j]     = pool_q[idx_q];
                idx_d         = idx_q - IDX_W'(1);
                if (idx_q == IDX_W'(1)) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        cards_d[k] = {pool_d[k], {STAT_W{1'b0}}};
                    end
`ifdef SHUFFLE_CHECK_EN
                    chk_d   = '0;
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef SHUFFLE_CHECK_EN
            S_CHECK: begin
                if (sym_cnt != (IDX_W+1)'(2)) begin
                    err_d = 1'b1;
                end
                chk_d = chk_q + SYM_W'(1);
                if (chk_q == SYM_W'(NUM_PAIRS - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            pool_q  <= '{default: '0};
            idx_q   <= '0;
            cards_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHUFFLE_CHECK_EN
            err_q   <= 1'b0;
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            pool_q  <= pool_d;
            idx_q   <= idx_d;
            cards_q <= cards_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHUFFLE_CHECK_EN
            err_q   <= err_d;
            chk_q   <= chk_d;
`endif
        end
    end

    assign arr_cards = cards_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef SHUFFLE_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_card_shuffler.sv
// Randomised self-checking bench for card_shuffler against a behavioural Fisher-Yates model.
module tb_card_shuffler;

    localparam int NP = 8;
    localparam int SW = 3;
    localparam int CW = 5;
    localparam int N  = 2 * NP;
`ifdef SHUFFLE_CHECK_EN
    localparam int EXTRA  = NP;
    localparam int EXTRA2 = 2;
`else
    localparam int EXTRA  = 0;
    localparam int EXTRA2 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic [7:0] seed = '0;
    logic [7:0] seed2 = '0;
    logic [N-1:0][CW-1:0] cards;
    logic busy, done;
    logic [3:0][2:0] cards2;
    logic busy2, done2;
`ifdef SHUFFLE_CHECK_EN
    logic err, err2;
`endif

    always #5 clk = ~clk;

    card_shuffler #(.NUM_PAIRS(NP), .SYM_W(SW), .CARD_W(CW), .LFSR_W(8), .LFSR_TAPS(8'hB8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .arr_cards(cards), .busy(busy), .done(done)
`ifdef SHUFFLE_CHECK_EN
        , .err(err)
`endif
    );

    card_shuffler #(.NUM_PAIRS(2), .SYM_W(1), .CARD_W(3), .LFSR_W(8), .LFSR_TAPS(8'hB8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .seed(seed2),
        .arr_cards(cards2), .busy(busy2), .done(done2)
`ifdef SHUFFLE_CHECK_EN
        , .err(err2)
`endif
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---- behavioural reference ----
    typedef int unsigned deck_t [64];

    function automatic int unsigned lfsr_step(int unsigned s);
        int unsigned fb = $countones(s & 32'hB8) & 1;
        return ((s << 1) | fb) & 32'hFF;
    endfunction

    function automatic int unsigned mulhi(int unsigned r, int unsigned m);
        return (r * m) >> 8;
    endfunction

    function automatic deck_t ref_deck(int unsigned sd, int unsigned np);
        deck_t d;
        int unsigned r = (sd == 0) ? 255 : sd;
        int unsigned j, t;
        for (int k = 0; k < 64; k++) d[k] = (k < 2*np) ? k / 2 : 0;
        for (int i = 2*np - 1; i >= 1; i--) begin
            r = lfsr_step(r);
            j = mulhi(r, i + 1);
            t = d[i]; d[i] = d[j]; d[j] = t;
        end
        return d;
    endfunction

    function automatic logic [127:0] pack(deck_t d, int unsigned np, int unsigned cw, int unsigned sw);
        logic [127:0] v = '0;
        for (int unsigned k = 0; k < 2*np; k++)
            v = v | (128'(d[k]) << (k*cw + cw - sw));
        return v;
    endfunction

    // Cycle-level expectation: run launches on an idle edge, deck lands N edges later.
    logic [127:0] m_cards = '0;
    logic [127:0] m_pending = '0;
    bit m_busy = 0, m_done = 0;
    int age = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cards = '0; m_busy = 0; m_done = 0; age = 0;
        end else if (!m_busy && start) begin
            m_busy = 1; m_done = 0; age = 0;
            m_pending = pack(ref_deck(seed, NP), NP, CW, SW);
        end else if (m_busy) begin
            age++;
            if (age == N) m_cards = m_pending;
            if (age == N + EXTRA) begin m_busy = 0; m_done = 1; end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("cards", cards, m_cards);
`ifdef SHUFFLE_CHECK_EN
            chk("err", err, 0);
`endif
        end
    end

    task automatic deck_props(string tag);
        int cnt;
        logic [CW-1:0] c;
        logic [1:0] lowor = '0;
        for (int s = 0; s < NP; s++) begin
            cnt = 0;
            for (int k = 0; k < N; k++) begin
                c = cards[k];
                if (int'(c[CW-1:CW-SW]) == s) cnt++;
            end
            chk({tag, " pair count"}, cnt, 2);
        end
        for (int k = 0; k < N; k++) begin
            c = cards[k];
            lowor = lowor | c[1:0];
        end
        chk({tag, " status bits"}, lowor, 0);
    endtask

    task automatic run(input logic [7:0] s, input bit noisy);
        int cyc;
        @(negedge clk); seed = s; start = 1;
        @(negedge clk); start = 0; cyc = 1;
        while (!done && cyc < 200) begin
            if (noisy) begin start = 1'($urandom_range(0, 1)); seed = 8'($urandom); end
            @(negedge clk); cyc++;
        end
        start = 0;
        chk("latency", cyc, N + 1 + EXTRA);
        chk("deck vs model", cards, pack(ref_deck(s, NP), NP, CW, SW));
    endtask

    initial begin
        logic [127:0] d1, d0;
        int cyc, dhigh;
        bit prevd;

        // Model pins, hand-computed.
        chk("pin lfsr 5A", lfsr_step(8'h5A), 8'hB4);
        chk("pin lfsr FF", lfsr_step(8'hFF), 8'hFE);
        chk("pin mulhi B4*16", mulhi(8'hB4, 16), 11);
        chk("pin mulhi FF*16", mulhi(8'hFF, 16), 15);
        chk("pin model 2-pair seed 01", pack(ref_deck(1, 2), 2, 3, 1), 12'h120);

        repeat (3) @(negedge clk);
        chk("reset cards", cards, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Basic, determinism, zero seed.
        run(8'h5A, 0); deck_props("5A"); d1 = cards;
        run(8'h5A, 0); chk("determinism", cards, d1);
        run(8'h00, 0); d0 = cards; chk("zero seed nonzero deck", (d0 != 0), 1);
        run(8'hFF, 0); chk("seed 00 == seed FF", cards, d0); deck_props("FF");

        // Handshake: pulses while busy are ignored.
        @(negedge clk); seed = 8'h77; start = 1;
        @(negedge clk); start = 0; cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == 5 || cyc == 10) begin start = 1; seed = 8'h33; end
            else start = 0;
            @(negedge clk); cyc++;
        end
        start = 0;
        chk("handshake latency", cyc, N + 1 + EXTRA);
        chk("handshake deck", cards, pack(ref_deck(8'h77, NP), NP, CW, SW));
        d1 = cards;
        repeat (2) @(negedge clk);
        seed = 8'hC3; start = 1;
        @(negedge clk); start = 0;
        chk("done falls after accept", done, 0);
        repeat (8) @(negedge clk);
        chk("old deck held while busy", cards, d1);
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        chk("second handshake done seen", done, 1);

        // Start held high: done must pulse for one cycle each run.
        @(negedge clk); seed = 8'($urandom); start = 1; prevd = 0; dhigh = 0;
        repeat (3 * (N + 2 + EXTRA)) begin
            @(negedge clk);
            if (done && prevd) dhigh++;
            prevd = done;
        end
        start = 0;
        chk("done single-cycle under held start", dhigh, 0);
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end

        // Randomised runs with noise on start/seed while busy.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(8'($urandom), 1);
        end
        deck_props("random");

        // Asynchronous reset mid-shuffle.
        @(negedge clk); seed = 8'h5A; start = 1;
        @(negedge clk); start = 0;
        repeat (6) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async rst cards", cards, 0);
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        @(negedge clk); #2 rst = 0;
        repeat (4) @(negedge clk);
        run(8'h5A, 0);

        // Two-pair instance.
        @(negedge clk); seed2 = 8'h01; start2 = 1;
        @(negedge clk); start2 = 0; cyc = 1;
        while (!done2 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("2-pair latency", cyc, 5 + EXTRA2);
        chk("2-pair deck", cards2, 12'h120);
        chk("2-pair deck vs model", cards2, pack(ref_deck(8'h01, 2), 2, 3, 1));
`ifdef SHUFFLE_CHECK_EN
        chk("2-pair err", err2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
